// File: rtl/cnn_window_scan.sv
// Read-side sequencer for the CNN input-image RAM: sweeps every 3x3 window in
// raster order and presents the registered taps over a valid/ready handshake.
module cnn_window_scan #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 3,
  parameter int AW    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [AW-1:0]     addr_rd,
  input  logic [8:0][1:0]   tap_in,
  output logic [17:0]       win_data,
  output logic [4:0]        win_row,
  output logic [4:0]        win_col,
  output logic              win_last,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  // The RAM address points at the bottom-right tap of the current window.
  localparam logic [AW-1:0] ADDR_FIRST = AW'((K - 1) * IMG_W + (K - 1));
  localparam logic [4:0]    ROW_MAX    = 5'(IMG_H - K);
  localparam logic [4:0]    COL_MAX    = 5'(IMG_W - K);

  state_t     state, state_nxt;
  logic [4:0] row, col;
  logic       adv, at_last;

  assign adv     = (state == SCAN) && (!win_valid || win_ready);
  assign at_last = (row == ROW_MAX) && (col == COL_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (adv && at_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (win_valid && win_ready) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture a window whenever the output stage is free, then step the scan;
  // a row change skips the K-1 edge pixels that cannot anchor a window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_rd   <= ADDR_FIRST;
      row       <= '0;
      col       <= '0;
      win_data  <= '0;
      win_row   <= '0;
      win_col   <= '0;
      win_last  <= 1'b0;
      win_valid <= 1'b0;
    end else if (adv) begin
      win_data  <= tap_in;
      win_row   <= row;
      win_col   <= col;
      win_last  <= at_last;
      win_valid <= 1'b1;
      if (at_last) begin
        row     <= '0;
        col     <= '0;
        addr_rd <= ADDR_FIRST;
      end else if (col == COL_MAX) begin
        col     <= '0;
        row     <= row + 5'd1;
        addr_rd <= addr_rd + AW'(K);
      end else begin
        col     <= col + 5'd1;
        addr_rd <= addr_rd + AW'(1);
      end
    end else if (win_valid && win_ready && (state == SCAN || state == DRAIN)) begin
      win_valid <= 1'b0;
    end
  end

endmodule
